// File: rtl/buzz_arbiter_pkg.sv
// Shared sound-path definitions: FSM state encoding, default timing and a
// saturating adder for the event-loss counter.
package buzz_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEF_NUM_SRC     = 3;
    localparam int DEF_HOLD_CYCLES = 5_000_000;
    localparam int DEF_GAP_CYCLES  = 100_000;
    localparam int DEF_CNT_W       = 23;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/evt_edge_detect.sv
// Rising-edge detector for the per-source event requests; the history register
// runs every cycle so a level held across mute is never seen as a new event.
module evt_edge_detect #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] evt_req,
    output logic [W-1:0] evt_edge
);

    logic [W-1:0] evt_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) evt_prev <= '0;
        else        evt_prev <= evt_req;
    end

    assign evt_edge = evt_req & ~evt_prev;

endmodule

// File: rtl/buzz_arbiter.sv
// Piezo buzzer arbiter: one-shot effects win by fixed priority for a hold time,
// background music plays only when idle.
//   state   | meaning
//   IDLE    | bgm on buzzer, serve lowest pending source
//   PLAY    | granted source on buzzer, hold timer running
//   GAP     | silent spacer between grants
module buzz_arbiter
    import buzz_arbiter_pkg::*;
#(
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_SRC-1:0] evt_req,
    input  logic [NUM_SRC-1:0] src_wave,
    input  logic               bgm_wave,
    output logic               buzz,
    output logic [NUM_SRC-1:0] grant,
    output logic               busy,
    output logic [7:0]         drop_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] evt_edge;
    logic [NUM_SRC-1:0] hi_edge, hi_sel, pend_sel, pend_in;
    logic               preempt, expire;
    logic [7:0]         drop_next;

    function automatic logic [NUM_SRC-1:0] lowest(input logic [NUM_SRC-1:0] v);
        return v & (~v + NUM_SRC'(1));
    endfunction

    function automatic logic [7:0] popc(input logic [NUM_SRC-1:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < NUM_SRC; i++) c = c + {7'd0, v[i]};
        return c;
    endfunction

    evt_edge_detect #(.W(NUM_SRC)) u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .evt_req  (evt_req),
        .evt_edge (evt_edge)
    );

    // Lower index = higher priority, so grant-1 masks exactly the sources above the grant.
    always_comb begin
        expire   = (state == ST_PLAY) && (cnt == '0);
        hi_edge  = evt_edge & (grant - NUM_SRC'(1));
        preempt  = (state == ST_PLAY) && !expire && (|hi_edge);
        hi_sel   = preempt ? lowest(hi_edge) : '0;
        pend_sel = lowest(pending);
        pend_in  = evt_edge;
        if (state == ST_PLAY && !expire) pend_in = evt_edge & ~grant & ~hi_sel;
        drop_next = sat_add8(drop_cnt, popc(pend_in & pending) + {7'd0, preempt});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            grant    <= '0;
            pending  <= '0;
            buzz     <= 1'b0;
            drop_cnt <= '0;
        end else if (!en) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            grant   <= '0;
            pending <= '0;
            buzz    <= 1'b0;
        end else begin
            drop_cnt <= drop_next;
            case (state)
                ST_IDLE: begin
                    buzz <= bgm_wave;
                    if (|pending) begin
                        grant   <= pend_sel;
                        pending <= (pending & ~pend_sel) | pend_in;
                        cnt     <= HOLD_LOAD;
                        state   <= ST_PLAY;
                    end else begin
                        pending <= pending | pend_in;
                    end
                end
                ST_PLAY: begin
                    buzz    <= |(src_wave & grant);
                    pending <= pending | pend_in;
                    if (expire) begin
                        grant <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= GAP_LOAD;
                            state <= ST_GAP;
                        end
                    end else if (preempt) begin
                        grant <= hi_sel;
                        cnt   <= HOLD_LOAD;
                    end else if (|(evt_edge & grant)) begin
                        cnt <= HOLD_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    buzz    <= 1'b0;
                    grant   <= '0;
                    pending <= pending | pend_in;
                    if (cnt == '0) state <= ST_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    buzz  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_buzz_arbiter.sv
// Directed bench for buzz_arbiter with short hold/gap times; expected values are
// hand-derived cycle counts and flags.
module tb_buzz_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] evt_req;
    logic [2:0] src_wave;
    logic       bgm_wave;
    logic       buzz;
    logic [2:0] grant;
    logic       busy;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    buzz_arbiter #(
        .NUM_SRC     (3),
        .HOLD_CYCLES (8),
        .GAP_CYCLES  (2),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .evt_req  (evt_req),
        .src_wave (src_wave),
        .bgm_wave (bgm_wave),
        .buzz     (buzz),
        .grant    (grant),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive cycles with grant == g, bounded so a stuck grant cannot hang.
    task automatic count_grant(input logic [2:0] g, output int n);
        n = 0;
        while (grant == g && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [7:0] pat;

        rst_n = 1'b0; en = 1'b1; evt_req = '0; src_wave = '0; bgm_wave = 1'b0;
        #12;
        chk("rst_buzz", buzz, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // 1: idle bgm passthrough
        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            bgm_wave = pat[i];
            tick();
            chk("t1_buzz_bgm", buzz, pat[i]);
            chk("t1_grant", grant, 0);
            chk("t1_busy", busy, 0);
        end
        bgm_wave = 1'b0;

        // 2: single event on src1
        src_wave = 3'b010;
        evt_req = 3'b010;
        tick();
        evt_req = '0;
        chk("t2_no_grant_yet", grant, 0);
        tick();
        chk("t2_grant", grant, 3'b010);
        chk("t2_busy", busy, 1);
        chk("t2_buzz_lag", buzz, 0);
        tick();
        chk("t2_buzz_src", buzz, 1);
        count_grant(3'b010, n);
        chk("t2_hold_len", n, 7);
        chk("t2_gap_grant", grant, 0);
        chk("t2_gap_busy", busy, 1);
        tick();
        chk("t2_gap_buzz", buzz, 0);
        chk("t2_gap_busy2", busy, 1);
        tick();
        chk("t2_idle", busy, 0);
        src_wave = '0;

        // 3: simultaneous src1+src2
        evt_req = 3'b110;
        tick();
        evt_req = '0;
        tick();
        chk("t3_first", grant, 3'b010);
        count_grant(3'b010, n);
        chk("t3_len1", n, 8);
        tick(); tick();
        chk("t3_idle_between", busy, 0);
        tick();
        chk("t3_second", grant, 3'b100);
        count_grant(3'b100, n);
        chk("t3_len2", n, 8);
        chk("t3_drop", drop_cnt, 0);
        tick(); tick();

        // 4: src0 preempts src2 at cnt=5
        evt_req = 3'b100;
        tick();
        evt_req = '0;
        tick();
        chk("t4_src2", grant, 3'b100);
        tick(); tick();
        evt_req = 3'b001;
        tick();
        evt_req = '0;
        chk("t4_preempt", grant, 3'b001);
        chk("t4_drop", drop_cnt, 1);
        count_grant(3'b001, n);
        chk("t4_len", n, 8);
        tick(); tick(); tick(); tick();
        chk("t4_no_replay", grant, 0);
        chk("t4_idle", busy, 0);

        // 5: src1 merged while src0 plays
        evt_req = 3'b001;
        tick();
        evt_req = '0;
        tick();
        chk("t5_src0", grant, 3'b001);
        tick();
        evt_req = 3'b010;
        tick();
        evt_req = '0;
        tick();
        evt_req = 3'b010;
        tick();
        evt_req = '0;
        chk("t5_drop", drop_cnt, 2);
        count_grant(3'b001, n);
        chk("t5_rest", n, 4);
        tick(); tick();
        chk("t5_idle", busy, 0);
        tick();
        chk("t5_src1", grant, 3'b010);
        count_grant(3'b010, n);
        chk("t5_len", n, 8);
        tick(); tick(); tick(); tick();
        chk("t5_once", grant, 0);
        chk("t5_drop_end", drop_cnt, 2);

        // 6: mute mid-play with pending, level across unmute, reset mid-gap
        src_wave = 3'b111;
        evt_req = 3'b001;
        tick();
        evt_req = '0;
        tick();
        tick();
        chk("t6_buzz_on", buzz, 1);
        evt_req = 3'b100;
        tick();
        evt_req = '0;
        en = 1'b0;
        tick();
        chk("t6_mute_buzz", buzz, 0);
        chk("t6_mute_grant", grant, 0);
        chk("t6_mute_busy", busy, 0);
        en = 1'b1;
        tick(); tick();
        chk("t6_flushed", grant, 0);
        chk("t6_flushed_busy", busy, 0);
        en = 1'b0;
        evt_req = 3'b100;
        tick(); tick();
        en = 1'b1;
        tick(); tick(); tick();
        chk("t6_level_grant", grant, 0);
        chk("t6_level_busy", busy, 0);
        chk("t6_drop", drop_cnt, 2);
        evt_req = '0;
        tick();

        evt_req = 3'b010;
        tick();
        evt_req = '0;
        tick();
        count_grant(3'b010, n);
        chk("t6_len", n, 8);
        chk("t6_in_gap", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_buzz", buzz, 0);
        chk("t6_rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();
        chk("t6_after_rst", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
